counter_updn_n: RTL and testbench

Parametrised up/down modulo counter, successor to the fixed 4-bit free-running counter. Adds configurable width and modulus, direction control, synchronous load, count enable with prescaler, and wrap or saturate mode. Registered status flags report wrap-around and saturation. Used as the general-purpose timebase and event counter in the design, driven from the system clock.

---
 rtl/counter_updn_n_if.sv | 25 ++
 rtl/counter_updn_n.sv | 87 ++++++++
 tb/tb_counter_updn_n.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/counter_updn_n_if.sv
// Control and status bundle for counter_updn_n: direction, mode, load and enable
// inputs, plus the registered count and its status flags.
interface counter_updn_n_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             sat;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             sat_hit;

  modport master (
    output en, up, sat, ld, ld_val,
    input  q, tc, wrap, sat_hit
  );

  modport slave (
    input  en, up, sat, ld, ld_val,
    output q, tc, wrap, sat_hit
  );
endinterface

// File: rtl/counter_updn_n.sv
// Parametrised up/down modulo counter with prescaler, synchronous load,
// wrap/saturate mode and registered wrap/saturation status.
module counter_updn_n #(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULO   = 16,
  parameter int              PRESCALE = 1
) (
  input  logic            ck,
  input  logic            res,
  counter_updn_n_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 64'd1);

  logic [WIDTH-1:0] q_reg, q_next, ld_clamped;
  logic             wrap_reg, wrap_next;
  logic             sat_hit_reg, sat_hit_next;
  logic             step;

  // The phase counter only exists when more than one enabled cycle makes a step.
  generate
    if (PRESCALE > 1) begin : g_prescale
      localparam int            PW      = $clog2(PRESCALE);
      localparam logic [PW-1:0] PH_LAST = PW'(PRESCALE - 1);
      logic [PW-1:0] phase_reg;

      always_ff @(posedge ck) begin
        if (res || bus.ld) begin
          phase_reg <= '0;
        end else if (bus.en) begin
          phase_reg <= (phase_reg == PH_LAST) ? '0 : phase_reg + PW'(1);
        end
      end

      assign step = bus.en && (phase_reg == PH_LAST);
    end else begin : g_no_prescale
      assign step = bus.en;
    end
  endgenerate

  always_comb begin
    ld_clamped   = (bus.ld_val > MAX_VAL) ? MAX_VAL : bus.ld_val;
    q_next       = q_reg;
    wrap_next    = 1'b0;
    sat_hit_next = sat_hit_reg;
    if (bus.ld) begin
      q_next       = ld_clamped;
      sat_hit_next = 1'b0;
    end else if (step) begin
      if (bus.up) begin
        if (q_reg < MAX_VAL) begin
          q_next = q_reg + WIDTH'(1);
        end else if (!bus.sat) begin
          q_next    = '0;
          wrap_next = 1'b1;
        end else begin
          sat_hit_next = 1'b1;
        end
      end else begin
        if (q_reg > '0) begin
          q_next = q_reg - WIDTH'(1);
        end else if (!bus.sat) begin
          q_next    = MAX_VAL;
          wrap_next = 1'b1;
        end else begin
          sat_hit_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ck) begin
    if (res) begin
      q_reg       <= '0;
      wrap_reg    <= 1'b0;
      sat_hit_reg <= 1'b0;
    end else begin
      q_reg       <= q_next;
      wrap_reg    <= wrap_next;
      sat_hit_reg <= sat_hit_next;
    end
  end

  assign bus.q       = q_reg;
  assign bus.wrap    = wrap_reg;
  assign bus.sat_hit = sat_hit_reg;
  assign bus.tc      = (bus.up && (q_reg == MAX_VAL)) || (!bus.up && (q_reg == '0));
endmodule

// File: tb/tb_counter_updn_n.sv
// Directed bench for counter_updn_n: three instances cover PRESCALE=1,
// PRESCALE=3 and the MODULO=2 back-to-back wrap corner.
module tb_counter_updn_n;
  logic ck = 1'b0;
  logic res0 = 1'b1;
  logic res1 = 1'b1;
  logic res2 = 1'b1;
  int checks = 0;
  int errors = 0;

  counter_updn_n_if #(.WIDTH(4)) i0 ();
  counter_updn_n_if #(.WIDTH(4)) i1 ();
  counter_updn_n_if #(.WIDTH(1)) i2 ();

  counter_updn_n #(.WIDTH(4), .MODULO(10), .PRESCALE(1)) d0 (.ck(ck), .res(res0), .bus(i0.slave));
  counter_updn_n #(.WIDTH(4), .MODULO(10), .PRESCALE(3)) d1 (.ck(ck), .res(res1), .bus(i1.slave));
  counter_updn_n #(.WIDTH(1), .MODULO(2),  .PRESCALE(1)) d2 (.ck(ck), .res(res2), .bus(i2.slave));

  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    i0.en = 1'b1; i0.up = 1'b1; i0.sat = 1'b0; i0.ld = 1'b1; i0.ld_val = 4'd5;
    res0 = 1'b1;
    tick();
    checks++;
    if (i0.q !== 4'd0 || i0.wrap !== 1'b0 || i0.sat_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: q=%0d wrap=%0b sat_hit=%0b, expected q=0 wrap=0 sat_hit=0", i0.q, i0.wrap, i0.sat_hit);
    end
    checks++;
    if (i0.tc !== 1'b0) begin errors++; $display("FAIL reset_tc_up: tc=%0b expected 0", i0.tc); end
    i0.up = 1'b0;
    #1;
    checks++;
    if (i0.tc !== 1'b1) begin errors++; $display("FAIL reset_tc_down: tc=%0b expected 1", i0.tc); end
    $display("test_reset: q=%0d tc(up=0)=%0b", i0.q, i0.tc);
  endtask

  task automatic test_wrap_up();
    logic [3:0] exp_q;
    i0.ld = 1'b0; i0.up = 1'b1; i0.en = 1'b1; i0.sat = 1'b0;
    res0 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_q = 4'(i % 10);
      checks++;
      if (i0.q !== exp_q || i0.wrap !== (i == 10) || i0.tc !== (exp_q == 4'd9)) begin
        errors++;
        $display("FAIL wrap_up[%0d]: q=%0d wrap=%0b tc=%0b, expected q=%0d wrap=%0b tc=%0b",
                 i, i0.q, i0.wrap, i0.tc, exp_q, (i == 10), (exp_q == 4'd9));
      end
    end
    $display("test_wrap_up: final q=%0d", i0.q);
  endtask

  task automatic test_wrap_down();
    logic [3:0] exp_q;
    res0 = 1'b1;
    tick();
    res0 = 1'b0; i0.up = 1'b0; i0.en = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      exp_q = 4'((20 - i) % 10);
      checks++;
      if (i0.q !== exp_q || i0.wrap !== (i == 1 || i == 11) || i0.tc !== (exp_q == 4'd0)) begin
        errors++;
        $display("FAIL wrap_down[%0d]: q=%0d wrap=%0b tc=%0b, expected q=%0d wrap=%0b tc=%0b",
                 i, i0.q, i0.wrap, i0.tc, exp_q, (i == 1 || i == 11), (exp_q == 4'd0));
      end
    end
    $display("test_wrap_down: final q=%0d", i0.q);
  endtask

  task automatic test_saturate();
    logic [3:0] exp_q [4] = '{4'd8, 4'd9, 4'd9, 4'd9};
    logic       exp_sh [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    i0.en = 1'b0; i0.up = 1'b1; i0.sat = 1'b1; i0.ld = 1'b1; i0.ld_val = 4'd7;
    tick();
    checks++;
    if (i0.q !== 4'd7 || i0.sat_hit !== 1'b0) begin
      errors++; $display("FAIL sat_load7: q=%0d sat_hit=%0b, expected q=7 sat_hit=0", i0.q, i0.sat_hit);
    end
    i0.ld = 1'b0; i0.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (i0.q !== exp_q[i] || i0.sat_hit !== exp_sh[i] || i0.wrap !== 1'b0) begin
        errors++;
        $display("FAIL saturate[%0d]: q=%0d sat_hit=%0b wrap=%0b, expected q=%0d sat_hit=%0b wrap=0",
                 i, i0.q, i0.sat_hit, i0.wrap, exp_q[i], exp_sh[i]);
      end
    end
    i0.ld = 1'b1; i0.ld_val = 4'd3;
    tick();
    checks++;
    if (i0.q !== 4'd3 || i0.sat_hit !== 1'b0) begin
      errors++; $display("FAIL sat_reload3: q=%0d sat_hit=%0b, expected q=3 sat_hit=0", i0.q, i0.sat_hit);
    end
    $display("test_saturate: q=%0d sat_hit=%0b", i0.q, i0.sat_hit);
  endtask

  task automatic test_load_priority();
    i0.sat = 1'b0; i0.up = 1'b1; i0.en = 1'b1; i0.ld = 1'b1; i0.ld_val = 4'd15;
    tick();
    checks++;
    if (i0.q !== 4'd9 || i0.wrap !== 1'b0) begin
      errors++; $display("FAIL load_clamp: q=%0d wrap=%0b, expected q=9 wrap=0", i0.q, i0.wrap);
    end
    // q=9 going up would wrap on a step; the load must win instead.
    i0.ld_val = 4'd5;
    tick();
    checks++;
    if (i0.q !== 4'd5 || i0.wrap !== 1'b0) begin
      errors++; $display("FAIL load_over_step: q=%0d wrap=%0b, expected q=5 wrap=0", i0.q, i0.wrap);
    end
    res0 = 1'b1; i0.ld_val = 4'd4;
    tick();
    checks++;
    if (i0.q !== 4'd0) begin errors++; $display("FAIL res_over_ld: q=%0d expected 0", i0.q); end
    res0 = 1'b0; i0.ld = 1'b0; i0.en = 1'b0;
    $display("test_load_priority: q=%0d", i0.q);
  endtask

  task automatic test_prescaler();
    logic [3:0] exp_run [6] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
    logic       en_pat  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] exp_pat [5] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
    i1.en = 1'b1; i1.up = 1'b1; i1.sat = 1'b0; i1.ld = 1'b0; i1.ld_val = 4'd0;
    res1 = 1'b1;
    tick();
    res1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (i1.q !== exp_run[i]) begin
        errors++; $display("FAIL prescale_run[%0d]: q=%0d expected %0d", i, i1.q, exp_run[i]);
      end
    end
    res1 = 1'b1;
    tick();
    res1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i1.en = en_pat[i];
      tick();
      checks++;
      if (i1.q !== exp_pat[i]) begin
        errors++; $display("FAIL prescale_hold[%0d]: q=%0d expected %0d", i, i1.q, exp_pat[i]);
      end
    end
    $display("test_prescaler: q=%0d", i1.q);
  endtask

  task automatic test_reset_mid();
    i1.en = 1'b0; i1.up = 1'b1; i1.sat = 1'b1; i1.ld = 1'b1; i1.ld_val = 4'd9;
    tick();
    i1.ld = 1'b0; i1.en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (i1.q !== 4'd9 || i1.sat_hit !== 1'b1) begin
      errors++; $display("FAIL mid_sat_setup: q=%0d sat_hit=%0b, expected q=9 sat_hit=1", i1.q, i1.sat_hit);
    end
    i1.up = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (i1.q !== 4'd6 || i1.sat_hit !== 1'b1) begin
      errors++; $display("FAIL mid_setup: q=%0d sat_hit=%0b, expected q=6 sat_hit=1", i1.q, i1.sat_hit);
    end
    res1 = 1'b1;
    tick();
    checks++;
    if (i1.q !== 4'd0 || i1.wrap !== 1'b0 || i1.sat_hit !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: q=%0d wrap=%0b sat_hit=%0b, expected 0 0 0", i1.q, i1.wrap, i1.sat_hit);
    end
    res1 = 1'b0; i1.up = 1'b1; i1.sat = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (i1.q !== ((i == 3) ? 4'd1 : 4'd0)) begin
        errors++; $display("FAIL mid_resume[%0d]: q=%0d expected %0d", i, i1.q, (i == 3) ? 1 : 0);
      end
    end
    $display("test_reset_mid: q=%0d", i1.q);
  endtask

  task automatic test_back_to_back();
    logic up_pat   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic en_pat   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic exp_q    [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic exp_wrap [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    i2.sat = 1'b0; i2.ld = 1'b0; i2.ld_val = 1'b0; i2.en = 1'b0; i2.up = 1'b1;
    res2 = 1'b1;
    tick();
    res2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i2.up = up_pat[i]; i2.en = en_pat[i];
      tick();
      checks++;
      if (i2.q !== exp_q[i] || i2.wrap !== exp_wrap[i]) begin
        errors++;
        $display("FAIL b2b_wrap[%0d]: q=%0b wrap=%0b, expected q=%0b wrap=%0b", i, i2.q, i2.wrap, exp_q[i], exp_wrap[i]);
      end
    end
    $display("test_back_to_back: q=%0b wrap=%0b", i2.q, i2.wrap);
  endtask

  initial begin
    i0.en = 1'b0; i0.up = 1'b1; i0.sat = 1'b0; i0.ld = 1'b0; i0.ld_val = '0;
    i1.en = 1'b0; i1.up = 1'b1; i1.sat = 1'b0; i1.ld = 1'b0; i1.ld_val = '0;
    i2.en = 1'b0; i2.up = 1'b1; i2.sat = 1'b0; i2.ld = 1'b0; i2.ld_val = '0;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load_priority();
    test_prescaler();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
